// File: rtl/rfid_frame_engine.sv
// rtl/rfid_frame_engine.sv - framed request parser, back-end command handshake and CRC-8 response/error frame transmitter
module rfid_frame_engine #(
  parameter int          MAX_PAYLOAD      = 16,
  parameter int          MAX_RSP          = 8,
  parameter logic [7:0]  REQ_MAGIC        = 8'hA5,
  parameter logic [7:0]  RSP_MAGIC        = 8'h5A,
  parameter logic [7:0]  CRC8_POLY        = 8'h07,
  parameter logic [7:0]  CRC_INIT         = 8'h00,
  parameter int          BYTE_TIMEOUT_CYC = 270000,
  parameter int          RSP_TIMEOUT_CYC  = 1350000
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [7:0]               rx_data,
  input  logic                     rx_valid,
  output logic [7:0]               tx_data,
  output logic                     tx_valid,
  input  logic                     tx_ready,
  output logic                     cmd_valid,
  input  logic                     cmd_ready,
  output logic [7:0]               cmd_op,
  output logic [7:0]               cmd_len,
  output logic [8*MAX_PAYLOAD-1:0] cmd_payload,
  input  logic                     rsp_valid,
  input  logic [7:0]               rsp_status,
  input  logic [7:0]               rsp_len,
  input  logic [8*MAX_RSP-1:0]     rsp_payload,
  output logic                     busy,
  output logic [15:0]              crc_err_cnt
);

  localparam logic [7:0]  MAXP     = 8'(MAX_PAYLOAD);
  localparam logic [7:0]  MAXR     = 8'(MAX_RSP);
  localparam logic [31:0] BYTE_LIM = 32'(BYTE_TIMEOUT_CYC - 1);
  localparam logic [31:0] RSP_LIM  = 32'(RSP_TIMEOUT_CYC - 1);

  typedef enum logic [2:0] {
    S_HUNT, S_OP, S_LEN, S_PAYLOAD, S_CRCCHK, S_ISSUE, S_RSPWAIT, S_TX
  } state_t;

  state_t                   st_q, st_d;
  logic [7:0]               op_q, op_d;
  logic [7:0]               len_q, len_d;
  logic [7:0]               idx_q, idx_d;
  logic [7:0]               crc_q, crc_d;
  logic [31:0]              cnt_q, cnt_d;
  logic [8*MAX_PAYLOAD-1:0] payload_q, payload_d;
  logic [7:0]               status_q, status_d;
  logic [7:0]               rlen_q, rlen_d;
  logic [8*MAX_RSP-1:0]     rdata_q, rdata_d;
  logic [8:0]               txi_q, txi_d;
  logic [15:0]              err_cnt_q, err_cnt_d;

  logic [7:0] tx_byte;
  logic [7:0] data_byte;
  logic       tx_last;
  logic       byte_to;

  function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic [7:0] data);
    logic [7:0] c;
    c = crc ^ data;
    for (int b = 0; b < 8; b++) begin
      c = c[7] ? ({c[6:0], 1'b0} ^ CRC8_POLY) : {c[6:0], 1'b0};
    end
    return c;
  endfunction

  // Response byte sequence: magic, status, rlen, rlen data bytes, crc
  always_comb begin
    data_byte = 8'h00;
    for (int i = 0; i < MAX_RSP; i++) begin
      if (txi_q == 9'(i + 3)) data_byte = rdata_q[8*i +: 8];
    end
    tx_last = (txi_q == ({1'b0, rlen_q} + 9'd3));
    if (txi_q == 9'd0)      tx_byte = RSP_MAGIC;
    else if (txi_q == 9'd1) tx_byte = status_q;
    else if (txi_q == 9'd2) tx_byte = rlen_q;
    else if (tx_last)       tx_byte = crc_q;
    else                    tx_byte = data_byte;
  end

  always_comb begin
    st_d      = st_q;
    op_d      = op_q;
    len_d     = len_q;
    idx_d     = idx_q;
    crc_d     = crc_q;
    cnt_d     = cnt_q + 32'd1;
    payload_d = payload_q;
    status_d  = status_q;
    rlen_d    = rlen_q;
    rdata_d   = rdata_q;
    txi_d     = txi_q;
    err_cnt_d = err_cnt_q;
    byte_to   = !rx_valid && (cnt_q >= BYTE_LIM);

    case (st_q)
      S_HUNT: begin
        if (rx_valid && rx_data == REQ_MAGIC) begin
          crc_d     = CRC_INIT;
          payload_d = '0;
          idx_d     = 8'd0;
          st_d      = S_OP;
        end
      end
      S_OP: begin
        if (rx_valid) begin
          op_d  = rx_data;
          crc_d = crc8_step(crc_q, rx_data);
          st_d  = S_LEN;
        end
      end
      S_LEN: begin
        if (rx_valid) begin
          len_d = rx_data;
          crc_d = crc8_step(crc_q, rx_data);
          idx_d = 8'd0;
          st_d  = (rx_data == 8'd0) ? S_CRCCHK : S_PAYLOAD;
        end
      end
      S_PAYLOAD: begin
        if (rx_valid) begin
          crc_d = crc8_step(crc_q, rx_data);
          for (int i = 0; i < MAX_PAYLOAD; i++) begin
            if (idx_q == 8'(i)) payload_d[8*i +: 8] = rx_data;
          end
          idx_d = idx_q + 8'd1;
          if (idx_q + 8'd1 == len_q) st_d = S_CRCCHK;
        end
      end
      S_CRCCHK: begin
        if (rx_valid) begin
          if (rx_data != crc_q) begin
            status_d = 8'hEC;
            rlen_d   = 8'd0;
            st_d     = S_TX;
            if (err_cnt_q != 16'hFFFF) err_cnt_d = err_cnt_q + 16'd1;
          end else if (len_q > MAXP) begin
            status_d = 8'hEB;
            rlen_d   = 8'd0;
            st_d     = S_TX;
          end else begin
            st_d = S_ISSUE;
          end
        end
      end
      S_ISSUE: begin
        if (cmd_ready) st_d = S_RSPWAIT;
      end
      S_RSPWAIT: begin
        if (rsp_valid) begin
          status_d = rsp_status;
          rlen_d   = (rsp_len > MAXR) ? MAXR : rsp_len;
          rdata_d  = rsp_payload;
          st_d     = S_TX;
        end else if (cnt_q >= RSP_LIM) begin
          status_d = 8'hEE;
          rlen_d   = 8'd0;
          st_d     = S_TX;
        end
      end
      S_TX: begin
        if (tx_ready) begin
          if (tx_last) begin
            st_d = S_HUNT;
          end else begin
            if (txi_q != 9'd0) crc_d = crc8_step(crc_q, tx_byte);
            txi_d = txi_q + 9'd1;
          end
        end
      end
      default: st_d = S_HUNT;
    endcase

    // A byte arriving in the same cycle as the limit keeps the frame alive
    if ((st_q == S_OP || st_q == S_LEN || st_q == S_PAYLOAD || st_q == S_CRCCHK) && byte_to) begin
      status_d = 8'hED;
      rlen_d   = 8'd0;
      st_d     = S_TX;
    end

    if (st_d == S_TX && st_q != S_TX) begin
      txi_d = 9'd0;
      crc_d = CRC_INIT;
    end

    if (st_d != st_q || rx_valid || st_q == S_HUNT || st_q == S_ISSUE || st_q == S_TX)
      cnt_d = 32'd0;
    if (st_q == S_RSPWAIT && st_d == S_RSPWAIT)
      cnt_d = cnt_q + 32'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q      <= S_HUNT;
      op_q      <= 8'd0;
      len_q     <= 8'd0;
      idx_q     <= 8'd0;
      crc_q     <= 8'd0;
      cnt_q     <= 32'd0;
      payload_q <= '0;
      status_q  <= 8'd0;
      rlen_q    <= 8'd0;
      rdata_q   <= '0;
      txi_q     <= 9'd0;
      err_cnt_q <= 16'd0;
    end else begin
      st_q      <= st_d;
      op_q      <= op_d;
      len_q     <= len_d;
      idx_q     <= idx_d;
      crc_q     <= crc_d;
      cnt_q     <= cnt_d;
      payload_q <= payload_d;
      status_q  <= status_d;
      rlen_q    <= rlen_d;
      rdata_q   <= rdata_d;
      txi_q     <= txi_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign busy        = (st_q != S_HUNT);
  assign cmd_valid   = (st_q == S_ISSUE);
  assign tx_valid    = (st_q == S_TX);
  assign tx_data     = tx_valid ? tx_byte : 8'h00;
  assign cmd_op      = op_q;
  assign cmd_len     = len_q;
  assign cmd_payload = payload_q;
  assign crc_err_cnt = err_cnt_q;

endmodule

// File: tb/tb_rfid_frame_engine.sv
// tb/tb_rfid_frame_engine.sv - table-driven and randomized bench for rfid_frame_engine against a frame-level model
module tb_rfid_frame_engine;

  localparam int MAXP = 4;
  localparam int MAXR = 8;
  localparam int BTO  = 40;
  localparam int RTO  = 80;

  logic              clk = 1'b0;
  logic              rst;
  logic [7:0]        rx_data;
  logic              rx_valid;
  logic [7:0]        tx_data;
  logic              tx_valid;
  logic              tx_ready;
  logic              cmd_valid;
  logic              cmd_ready;
  logic [7:0]        cmd_op;
  logic [7:0]        cmd_len;
  logic [8*MAXP-1:0] cmd_payload;
  logic              rsp_valid;
  logic [7:0]        rsp_status;
  logic [7:0]        rsp_len;
  logic [8*MAXR-1:0] rsp_payload;
  logic              busy;
  logic [15:0]       crc_err_cnt;

  rfid_frame_engine #(
    .MAX_PAYLOAD(MAXP), .MAX_RSP(MAXR), .REQ_MAGIC(8'hA5), .RSP_MAGIC(8'h5A),
    .CRC8_POLY(8'h07), .CRC_INIT(8'h00), .BYTE_TIMEOUT_CYC(BTO), .RSP_TIMEOUT_CYC(RTO)
  ) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_len(cmd_len),
    .cmd_payload(cmd_payload), .rsp_valid(rsp_valid), .rsp_status(rsp_status),
    .rsp_len(rsp_len), .rsp_payload(rsp_payload), .busy(busy), .crc_err_cnt(crc_err_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] op;
    logic [7:0] len;
    logic       bad;
    logic [7:0] rstat;
    logic [7:0] rlen;
    logic       exp_cmd;
    logic [7:0] exp_status;
    logic [7:0] exp_rlen;
  } vec_t;

  int         checks = 0;
  int         failures = 0;
  int         crc_model = 0;
  bit         rand_ready = 1'b0;
  bit         cmd_seen;
  logic [7:0] txq[$];
  logic [7:0] exp_q[$];
  vec_t       vecs[7];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Bit-serial MSB-first CRC-8 (poly 07, seed 00)
  function automatic logic [7:0] crc_add(input logic [7:0] crc, input logic [7:0] d);
    logic [7:0] c;
    logic       fb;
    c = crc;
    for (int b = 7; b >= 0; b--) begin
      fb = c[7] ^ d[b];
      c  = {c[6:0], 1'b0};
      if (fb) c = c ^ 8'h07;
    end
    return c;
  endfunction

  // Transmitter side: random or always-ready, logs accepted bytes
  initial begin
    tx_ready = 1'b0;
    forever begin
      @(negedge clk);
      tx_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      if (cmd_valid) cmd_seen = 1'b1;
      if (tx_valid && tx_ready && !rst) txq.push_back(tx_data);
    end
  end

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic set_exp(input logic [7:0] st, input int n);
    logic [7:0] crc;
    logic [7:0] b;
    exp_q.delete();
    exp_q.push_back(8'h5A);
    exp_q.push_back(st);
    exp_q.push_back(8'(n));
    crc = crc_add(8'h00, st);
    crc = crc_add(crc, 8'(n));
    for (int i = 0; i < n; i++) begin
      b = rsp_payload[8*i +: 8];
      exp_q.push_back(b);
      crc = crc_add(crc, b);
    end
    exp_q.push_back(crc);
  endtask

  task automatic set_lit4(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c, input logic [7:0] d);
    exp_q.delete();
    exp_q.push_back(a);
    exp_q.push_back(b);
    exp_q.push_back(c);
    exp_q.push_back(d);
  endtask

  task automatic wait_and_check(input string nm);
    int k;
    k = 0;
    while ((txq.size() < exp_q.size() || busy) && k < 3000) begin
      @(negedge clk);
      k++;
    end
    chk({nm, " frame done"}, 64'(k < 3000), 64'd1);
    chk({nm, " frame len"}, 64'(txq.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i < txq.size()) chk($sformatf("%s byte%0d", nm, i), 64'(txq[i]), 64'(exp_q[i]));
    end
  endtask

  task automatic handshake_and_respond(input logic [7:0] rstat, input logic [7:0] rlen);
    idle($urandom_range(0, 3));
    cmd_ready = 1'b1;
    @(negedge clk);
    cmd_ready = 1'b0;
    idle($urandom_range(1, 5));
    rsp_status  = rstat;
    rsp_len     = rlen;
    rsp_payload = {$urandom, $urandom};
    rsp_valid   = 1'b1;
    @(negedge clk);
    rsp_valid = 1'b0;
  endtask

  task automatic run_frame(input logic [7:0] op, input logic [7:0] len, input bit bad,
                           input logic [7:0] rstat, input logic [7:0] rlen, input string nm);
    logic [7:0]        pl[$];
    logic [7:0]        crc;
    logic [8*MAXP-1:0] exp_pl;
    bit                exp_cmd;
    int                n;
    pl.delete();
    exp_pl = '0;
    crc = crc_add(8'h00, op);
    crc = crc_add(crc, len);
    for (int i = 0; i < int'(len); i++) begin
      pl.push_back(8'($urandom));
      crc = crc_add(crc, pl[i]);
      if (i < MAXP) exp_pl[8*i +: 8] = pl[i];
    end
    if (bad) crc = crc ^ (8'h01 << $urandom_range(0, 7));
    txq.delete();
    cmd_seen = 1'b0;
    send_byte(8'hA5);
    send_byte(op);
    send_byte(len);
    for (int i = 0; i < int'(len); i++) send_byte(pl[i]);
    send_byte(crc);
    exp_cmd = !bad && (int'(len) <= MAXP);
    if (exp_cmd) begin
      chk({nm, " cmd_valid"}, 64'(cmd_valid), 64'd1);
      chk({nm, " cmd_op"}, 64'(cmd_op), 64'(op));
      chk({nm, " cmd_len"}, 64'(cmd_len), 64'(len));
      chk({nm, " cmd_payload"}, 64'(cmd_payload), 64'(exp_pl));
      handshake_and_respond(rstat, rlen);
      n = (int'(rlen) > MAXR) ? MAXR : int'(rlen);
      set_exp(rstat, n);
    end else begin
      set_exp(bad ? 8'hEC : 8'hEB, 0);
    end
    wait_and_check(nm);
    chk({nm, " cmd seen"}, 64'(cmd_seen), 64'(exp_cmd));
    if (bad) crc_model++;
    chk({nm, " crc_err_cnt"}, 64'(crc_err_cnt), 64'(crc_model));
  endtask

  initial begin
    int k;
    rst = 1'b1; rx_data = 8'h00; rx_valid = 1'b0; cmd_ready = 1'b0;
    rsp_valid = 1'b0; rsp_status = 8'h00; rsp_len = 8'h00; rsp_payload = '0;

    vecs[0] = '{8'h21, 8'd0, 1'b0, 8'h01, 8'd0,  1'b1, 8'h01, 8'd0};
    vecs[1] = '{8'h22, 8'd3, 1'b0, 8'h02, 8'd5,  1'b1, 8'h02, 8'd5};
    vecs[2] = '{8'h23, 8'd4, 1'b0, 8'h03, 8'd8,  1'b1, 8'h03, 8'd8};
    vecs[3] = '{8'h24, 8'd5, 1'b0, 8'h00, 8'd0,  1'b0, 8'hEB, 8'd0};
    vecs[4] = '{8'h25, 8'd2, 1'b1, 8'h00, 8'd0,  1'b0, 8'hEC, 8'd0};
    vecs[5] = '{8'h26, 8'd1, 1'b0, 8'h44, 8'd20, 1'b1, 8'h44, 8'd8};
    vecs[6] = '{8'h27, 8'd6, 1'b0, 8'h00, 8'd9,  1'b0, 8'hEB, 8'd0};

    idle(3);
    chk("reset tx_valid", 64'(tx_valid), 64'd0);
    chk("reset tx_data", 64'(tx_data), 64'd0);
    chk("reset cmd_valid", 64'(cmd_valid), 64'd0);
    chk("reset busy", 64'(busy), 64'd0);
    chk("reset cmd_op", 64'(cmd_op), 64'd0);
    chk("reset cmd_len", 64'(cmd_len), 64'd0);
    chk("reset cmd_payload", 64'(cmd_payload), 64'd0);
    chk("reset crc_err_cnt", 64'(crc_err_cnt), 64'd0);
    rst = 1'b0;
    idle(2);

    // Literal frames: good verify and bad CRC
    txq.delete();
    send_byte(8'hA5); send_byte(8'h10); send_byte(8'h00); send_byte(8'h57);
    chk("verify cmd_valid", 64'(cmd_valid), 64'd1);
    chk("verify cmd_op", 64'(cmd_op), 64'h10);
    chk("verify cmd_len", 64'(cmd_len), 64'h00);
    handshake_and_respond(8'h01, 8'h00);
    set_lit4(8'h5A, 8'h01, 8'h00, 8'h15);
    wait_and_check("verify");

    txq.delete();
    cmd_seen = 1'b0;
    send_byte(8'hA5); send_byte(8'h10); send_byte(8'h00); send_byte(8'h58);
    set_lit4(8'h5A, 8'hEC, 8'h00, 8'hBF);
    wait_and_check("badcrc");
    chk("badcrc cmd seen", 64'(cmd_seen), 64'd0);
    crc_model = 1;
    chk("badcrc crc_err_cnt", 64'(crc_err_cnt), 64'd1);

    for (int i = 0; i < 7; i++) begin
      rand_ready = (i % 2) == 1;
      run_frame(vecs[i].op, vecs[i].len, vecs[i].bad, vecs[i].rstat, vecs[i].rlen, $sformatf("vec%0d", i));
      chk($sformatf("vec%0d tbl status", i), 64'(txq.size() > 1 ? txq[1] : 8'hXX), 64'(vecs[i].exp_status));
      chk($sformatf("vec%0d tbl rlen", i), 64'(txq.size() > 2 ? txq[2] : 8'hXX), 64'(vecs[i].exp_rlen));
      chk($sformatf("vec%0d tbl cmd", i), 64'(cmd_seen), 64'(vecs[i].exp_cmd));
    end
    rand_ready = 1'b0;

    // cmd_ready already high; rsp_valid in the handshake cycle must be ignored
    txq.delete();
    cmd_ready = 1'b1;
    send_byte(8'hA5); send_byte(8'h10); send_byte(8'h00); send_byte(8'h57);
    chk("early cmd_valid", 64'(cmd_valid), 64'd1);
    rsp_status = 8'hAA; rsp_len = 8'd0; rsp_valid = 1'b1;
    @(negedge clk);
    chk("early cmd_valid one cycle", 64'(cmd_valid), 64'd0);
    cmd_ready = 1'b0;
    rsp_status = 8'hBB;
    @(negedge clk);
    rsp_valid = 1'b0;
    set_exp(8'hBB, 0);
    wait_and_check("early");

    // Inter-byte stall
    txq.delete();
    send_byte(8'hA5); send_byte(8'h10);
    k = 0;
    while (!tx_valid && k < 500) begin
      @(negedge clk);
      k++;
    end
    chk("byte timeout latency", 64'(k >= BTO && k <= BTO + 2), 64'd1);
    set_exp(8'hED, 0);
    wait_and_check("bytetimeout");
    chk("bytetimeout busy", 64'(busy), 64'd0);

    // Back-end silence
    txq.delete();
    send_byte(8'hA5); send_byte(8'h10); send_byte(8'h00); send_byte(8'h57);
    cmd_ready = 1'b1;
    @(negedge clk);
    cmd_ready = 1'b0;
    k = 0;
    while (!tx_valid && k < 500) begin
      @(negedge clk);
      k++;
    end
    chk("rsp timeout latency", 64'(k >= RTO && k <= RTO + 2), 64'd1);
    set_exp(8'hEE, 0);
    wait_and_check("rsptimeout");

    rand_ready = 1'b1;
    for (int i = 0; i < 25; i++) begin
      run_frame(8'($urandom), 8'($urandom_range(0, 6)), $urandom_range(0, 4) == 0,
                8'($urandom), 8'($urandom_range(0, 12)), $sformatf("rnd%0d", i));
    end

    // Reset in the middle of a response frame
    txq.delete();
    send_byte(8'hA5); send_byte(8'h10); send_byte(8'h00); send_byte(8'h57);
    handshake_and_respond(8'h01, 8'd8);
    k = 0;
    while (!(txq.size() >= 2 && tx_valid) && k < 500) begin
      @(negedge clk);
      k++;
    end
    chk("midtx reached", 64'(tx_valid), 64'd1);
    @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("midtx rst tx_valid", 64'(tx_valid), 64'd0);
    chk("midtx rst busy", 64'(busy), 64'd0);
    chk("midtx rst crc_err_cnt", 64'(crc_err_cnt), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    crc_model = 0;
    idle(2);
    run_frame(8'h31, 8'd2, 1'b0, 8'h05, 8'd3, "postrst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rfid_frame_engine.md
# rfid_frame_engine

Parametrised framed-command engine sitting between the UART byte layer and the authentication back end. It hunts for a magic byte and parses op/length/payload/CRC-8 request frames of up to `MAX_PAYLOAD` bytes. It hands each validated command to the back end over a valid/ready handshake, then transmits a full CRC-protected response frame carrying status and up to `MAX_RSP` data bytes. It also generates error frames for CRC failure, over-length requests, inter-byte timeouts and back-end timeouts.

## Interface
Parameters:
- `MAX_PAYLOAD`, 16: maximum stored request payload bytes (1..255).
- `MAX_RSP`, 8: maximum response data bytes (0..255).
- `REQ_MAGIC`, 8'hA5: request start byte.
- `RSP_MAGIC`, 8'h5A: response start byte.
- `CRC8_POLY`, 8'h07: CRC polynomial.
- `CRC_INIT`, 8'h00: CRC seed.
- `BYTE_TIMEOUT_CYC`, 270000: maximum idle cycles between request bytes once a frame has started.
- `RSP_TIMEOUT_CYC`, 1350000: maximum cycles from command acceptance to `rsp_valid`.

Ports:
- `clk` in 1: the single clock.
- `rst` in 1: asynchronous, active-high reset.
- `rx_data` in 8: received byte.
- `rx_valid` in 1: one-cycle strobe qualifying `rx_data`.
- `tx_data` out 8: byte to transmit.
- `tx_valid` out 1: transmit request.
- `tx_ready` in 1: transmitter accepts `tx_data` when `tx_valid && tx_ready`.
- `cmd_valid` out 1: validated command available.
- `cmd_ready` in 1: back end accepts the command.
- `cmd_op` out 8: command opcode.
- `cmd_len` out 8: received LEN field, unclamped.
- `cmd_payload` out 8*MAX_PAYLOAD: payload, byte i at `[8i +: 8]`, unused bytes zero.
- `rsp_valid` in 1: back-end response strobe.
- `rsp_status` in 8: response status.
- `rsp_len` in 8: response data length.
- `rsp_payload` in 8*MAX_RSP: response data, byte i at `[8i +: 8]`.
- `busy` out 1: high in any state other than HUNT.
- `crc_err_cnt` out 16: saturating count of CRC failures.

## Operation
- Request frame: `REQ_MAGIC`, OP, LEN, LEN payload bytes, CRC.
- Response frame: `RSP_MAGIC`, STATUS, RLEN, RLEN bytes, CRC.
- CRC-8: MSB-first, no reflection, seeded with `CRC_INIT`. Request CRC covers OP, LEN and payload; response CRC covers STATUS, RLEN and data. Each byte is processed in one cycle, 8 shifts unrolled.
- States and transitions:
  - HUNT: non-magic bytes are ignored. On magic: CRC seeded, payload cleared, go to OP.
  - OP, LEN: capture the byte. If LEN=0, go to CRC; otherwise go to PAYLOAD.
  - PAYLOAD: store byte i while i < `MAX_PAYLOAD`; excess bytes update the CRC but are discarded. After LEN bytes, go to CRCCHK.
  - CRCCHK:
    - CRC mismatch: status 8'hEC and `crc_err_cnt` increments.
    - LEN > `MAX_PAYLOAD` (checked after CRC match): status 8'hEB.
    - Otherwise: go to ISSUE.
  - ISSUE: hold `cmd_valid` until `cmd_ready`, then go to RSPWAIT.
  - RSPWAIT: capture response fields on the first `rsp_valid`. RLEN = min(`rsp_len`, `MAX_RSP`). Go to TX.
  - TX: send MAGIC, STATUS, RLEN, data, CRC, then return to HUNT.
- Error frames always have RLEN=0.
- Inter-byte timeout: in OP, LEN, PAYLOAD or CRCCHK, if the counter reaches `BYTE_TIMEOUT_CYC` with no `rx_valid`, send an error frame with status 8'hED.
- Back-end timeout: in RSPWAIT, if `RSP_TIMEOUT_CYC` elapses, send status 8'hEE. A later `rsp_valid` is ignored.
- ISSUE has no timeout. The back end must eventually assert `cmd_ready`.
- `rx_valid` outside the HUNT..CRCCHK states (ISSUE, RSPWAIT, TX) is dropped silently.
- `crc_err_cnt` saturates at 16'hFFFF.

## Timing
- Reset state: HUNT. All outputs are 0, `cmd_payload` is all-zero and `crc_err_cnt` is 0.
- Reset mid-frame or mid-TX aborts immediately. No partial frame is resumed.
- Command issue: `cmd_valid` rises the cycle after the CRC byte's `rx_valid`. `cmd_op`, `cmd_len` and `cmd_payload` are stable while `cmd_valid` is high and until the next frame starts.
- If `cmd_ready` is already high, the handshake completes in the first `cmd_valid` cycle.
- `rsp_valid` in the same cycle as the `cmd_valid && cmd_ready` handshake is not captured. Capture starts the following cycle.
- Response start: `tx_valid` rises the cycle after response capture or error detection. `tx_data` is held until `tx_ready`. The next byte is presented the cycle after acceptance, and `tx_valid` stays high between bytes.
- `tx_valid` falls the cycle after the CRC byte is accepted.
- Timeout counters clear on every `rx_valid` and on every state entry.
- A timeout and an `rx_valid` in the same cycle: the byte wins.

## Test plan
- Good verify frame: send A5 10 00 57, back end returns status 01 with `rsp_len` 0. Required: `cmd_op`=10, `cmd_len`=0, and transmitted bytes 5A 01 00 15.
- Bad CRC: send A5 10 00 58. Required: no `cmd_valid`, transmitted bytes 5A EC 00 BF, and `crc_err_cnt`=1.
- Over-length request: with `MAX_PAYLOAD`=4, send LEN=6 with correct CRC. Required: no `cmd_valid`, and status EB in the response.
- Inter-byte stall: send A5 10, then idle for `BYTE_TIMEOUT_CYC`. Required: status ED frame, then `busy`=0.
- Response clamping and back-pressure: `rsp_len`=20 with `MAX_RSP`=8, and `tx_ready` toggling at random. Required: RLEN=08, all 8 data bytes in order, correct CRC, and no byte dropped or repeated.
- Back-end silence: never assert `rsp_valid`. Required: status EE after `RSP_TIMEOUT_CYC`. Additionally, asserting `rst` mid-TX must force `tx_valid`=0 immediately.
